col_fifo_array: RTL and testbench

Parametrised per-column elastic buffer array. It generalises the fixed 4-column, 1-bit-valid column pipeline into COLS independent lanes, each with DATA_W-bit payload, a DEPTH-entry FIFO, and a valid/ready handshake on both sides. It sits between the column producer stage and the column consumer stage of the array datapath, absorbing per-column backpressure. It also reports per-lane occupancy.

---
 rtl/col_fifo_pkg.sv | 21 ++
 rtl/col_fifo_array_if.sv | 51 +++++
 rtl/col_fifo_lane.sv | 87 ++++++++
 rtl/col_fifo_array.sv | 55 +++++
 tb/tb_col_fifo_array.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/col_fifo_pkg.sv
// rtl/col_fifo_pkg.sv - shared types and helpers for the per-column FIFO array
package col_fifo_pkg;

  // Lane state fields are sized for the largest supported depth; lanes mask down.
  localparam int PTR_W_MAX = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [PTR_W_MAX-1:0] rd_ptr;
    logic [PTR_W_MAX-1:0] wr_ptr;
    logic [PTR_W_MAX:0]   count;
  } lane_state_t;

  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/col_fifo_array_if.sv
// rtl/col_fifo_array_if.sv - per-lane write/read handshake bundle; optional COL_FIFO_PARITY_EN signals
interface col_fifo_array_if #(
  parameter int COLS   = 4,
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
);
  import col_fifo_pkg::*;

  localparam int CNT_W = cnt_w(DEPTH);

  logic                         flush;
  logic [COLS-1:0]              ival;
  logic [COLS-1:0][DATA_W-1:0]  idata;
  logic [COLS-1:0]              iready;
  logic [COLS-1:0]              oval;
  logic [COLS-1:0][DATA_W-1:0]  odata;
  logic [COLS-1:0]              oready;
  logic [COLS-1:0][CNT_W-1:0]   ocount;
  logic                         oempty_all;
`ifdef COL_FIFO_PARITY_EN
  logic [COLS-1:0]              iparity;
  logic [COLS-1:0]              oerr;
`endif

  modport master (
    output flush, ival, idata,
`ifdef COL_FIFO_PARITY_EN
    iparity,
`endif
    oready,
    input  iready, oval, odata, ocount,
`ifdef COL_FIFO_PARITY_EN
    oerr,
`endif
    oempty_all
  );

  modport slave (
    input  flush, ival, idata,
`ifdef COL_FIFO_PARITY_EN
    iparity,
`endif
    oready,
    output iready, oval, odata, ocount,
`ifdef COL_FIFO_PARITY_EN
    oerr,
`endif
    oempty_all
  );

endinterface

// File: rtl/col_fifo_lane.sv
// rtl/col_fifo_lane.sv - one DEPTH-entry elastic lane; parity check under COL_FIFO_PARITY_EN
module col_fifo_lane
  import col_fifo_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              flush_i,
  input  logic              ival_i,
  input  logic [DATA_W-1:0] idata_i,
  output logic              iready_o,
  output logic              oval_o,
  output logic [DATA_W-1:0] odata_o,
  input  logic              oready_i,
`ifdef COL_FIFO_PARITY_EN
  input  logic              iparity_i,
  output logic              oerr_o,
`endif
  output logic [CNT_W-1:0]  ocount_o
);

  localparam logic [PTR_W_MAX-1:0] PTR_MASK = PTR_W_MAX'(DEPTH - 1);
  localparam logic [PTR_W_MAX:0]   FULL_CNT = (PTR_W_MAX + 1)'(DEPTH);

  lane_state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic push, pop;

  assign iready_o = (state_q.count != FULL_CNT);
  assign oval_o   = (state_q.count != '0);
  assign push     = ival_i & iready_o;
  assign pop      = oval_o & oready_i;
  assign odata_o  = mem_q[state_q.rd_ptr[PTR_W-1:0]];
  assign ocount_o = state_q.count[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = '0;
    end else begin
      if (push) state_d.wr_ptr = (state_q.wr_ptr + 1'b1) & PTR_MASK;
      if (pop)  state_d.rd_ptr = (state_q.rd_ptr + 1'b1) & PTR_MASK;
      if (push && !pop)      state_d.count = state_q.count + 1'b1;
      else if (pop && !push) state_d.count = state_q.count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= '0;
    else       state_q <= state_d;
  end

  // Storage is deliberately left unreset; a flushed push must not land.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[state_q.wr_ptr[PTR_W-1:0]] <= idata_i;
  end

`ifdef COL_FIFO_PARITY_EN
  logic par_q [DEPTH];
  logic err_q, err_d;
  logic head_bad;

  assign head_bad = par_q[state_q.rd_ptr[PTR_W-1:0]]
                    != even_parity(64'(odata_o));
  assign oerr_o   = err_q;

  always_comb begin
    err_d = err_q;
    if (flush_i)              err_d = 1'b0;
    else if (pop && head_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i) par_q[state_q.wr_ptr[PTR_W-1:0]] <= iparity_i;
  end
`endif

endmodule

// File: rtl/col_fifo_array.sv
// rtl/col_fifo_array.sv - COLS independent elastic lanes; optional parity via COL_FIFO_PARITY_EN
module col_fifo_array
  import col_fifo_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rstb,
  col_fifo_array_if.slave  bus
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [COLS-1:0]             iready_w;
  logic [COLS-1:0]             oval_w;
  logic [COLS-1:0][DATA_W-1:0] odata_w;
  logic [COLS-1:0][CNT_W-1:0]  ocount_w;
`ifdef COL_FIFO_PARITY_EN
  logic [COLS-1:0]             oerr_w;
`endif

  for (genvar column = 0; column < COLS; column++) begin : g_lane
    col_fifo_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk       (clk),
      .rstb      (rstb),
      .flush_i   (bus.flush),
      .ival_i    (bus.ival[column]),
      .idata_i   (bus.idata[column]),
      .iready_o  (iready_w[column]),
      .oval_o    (oval_w[column]),
      .odata_o   (odata_w[column]),
      .oready_i  (bus.oready[column]),
`ifdef COL_FIFO_PARITY_EN
      .iparity_i (bus.iparity[column]),
      .oerr_o    (oerr_w[column]),
`endif
      .ocount_o  (ocount_w[column])
    );
  end

  assign bus.iready     = iready_w;
  assign bus.oval       = oval_w;
  assign bus.odata      = odata_w;
  assign bus.ocount     = ocount_w;
  assign bus.oempty_all = &(~oval_w);
`ifdef COL_FIFO_PARITY_EN
  assign bus.oerr       = oerr_w;
`endif

endmodule

// File: tb/tb_col_fifo_array.sv
// tb/tb_col_fifo_array.sv - directed bench for col_fifo_array (COLS=4, DATA_W=2, DEPTH=4)
module tb_col_fifo_array;

  logic clk;
  logic rstb;
  int checks;
  int failures;

  col_fifo_array_if #(.COLS(4), .DATA_W(2), .DEPTH(4)) bus ();

  col_fifo_array #(.COLS(4), .DATA_W(2), .DEPTH(4)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    bus.flush = 1'b0;
    bus.ival = '0;
    bus.idata = '0;
    bus.oready = '0;
`ifdef COL_FIFO_PARITY_EN
    bus.iparity = '0;
`endif
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (bus.oval !== 4'b0000) begin failures++; $display("FAIL reset_oval got=%b exp=0000", bus.oval); end
    checks++;
    if (bus.iready !== 4'b1111) begin failures++; $display("FAIL reset_iready got=%b exp=1111", bus.iready); end
    checks++;
    if (bus.ocount !== 12'd0) begin failures++; $display("FAIL reset_ocount got=%h exp=000", bus.ocount); end
    checks++;
    if (bus.oempty_all !== 1'b1) begin failures++; $display("FAIL reset_oempty got=%b exp=1", bus.oempty_all); end
    step();
    rstb = 1'b1;
    step();
    checks++;
    if (bus.oval !== 4'b0000 || bus.iready !== 4'b1111) begin
      failures++; $display("FAIL idle_after_reset oval=%b iready=%b exp=0000/1111", bus.oval, bus.iready);
    end
  endtask

  task automatic test_fill_drain();
    logic [1:0] vals [4];
    vals = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      bus.ival[0] = 1'b1;
      bus.idata[0] = vals[i];
      step();
    end
    checks++;
    if (bus.ocount[0] !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.ocount[0]); end
    checks++;
    if (bus.iready[0] !== 1'b0) begin failures++; $display("FAIL fill_iready got=%b exp=0", bus.iready[0]); end
    bus.idata[0] = 2'd3;
    step();
    checks++;
    if (bus.ocount[0] !== 3'd4) begin failures++; $display("FAIL overflow_count got=%0d exp=4", bus.ocount[0]); end
    bus.ival[0] = 1'b0;
    bus.oready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.oval[0] !== 1'b1 || bus.odata[0] !== vals[i]) begin
        failures++; $display("FAIL drain_%0d oval=%b data=%0d exp=1/%0d", i, bus.oval[0], bus.odata[0], vals[i]);
      end
      step();
      if (i == 0) begin
        checks++;
        if (bus.iready[0] !== 1'b1) begin failures++; $display("FAIL iready_rise got=%b exp=1", bus.iready[0]); end
      end
    end
    bus.oready[0] = 1'b0;
    checks++;
    if (bus.oval[0] !== 1'b0 || bus.oempty_all !== 1'b1 || bus.ocount[0] !== 3'd0) begin
      failures++; $display("FAIL drain_empty oval=%b oempty=%b cnt=%0d exp=0/1/0", bus.oval[0], bus.oempty_all, bus.ocount[0]);
    end
  endtask

  task automatic test_stream();
    bus.ival[2] = 1'b1;
    bus.oready[2] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.idata[2] = 2'(i);
      step();
      checks++;
      if (bus.ocount[2] !== 3'd1 || bus.odata[2] !== 2'(i)) begin
        failures++; $display("FAIL stream_%0d cnt=%0d data=%0d exp=1/%0d", i, bus.ocount[2], bus.odata[2], i % 4);
      end
    end
    bus.ival[2] = 1'b0;
    step();
    bus.oready[2] = 1'b0;
    checks++;
    if (bus.ocount[2] !== 3'd0) begin failures++; $display("FAIL stream_end cnt=%0d exp=0", bus.ocount[2]); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] vals [4];
    vals = '{2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 4; i++) begin
      bus.ival[1] = 1'b1;
      bus.idata[1] = vals[i];
      step();
    end
    checks++;
    if (bus.iready[1] !== 1'b0) begin failures++; $display("FAIL full1_iready got=%b exp=0", bus.iready[1]); end
    bus.idata[1] = 2'd2;
    bus.oready[1] = 1'b1;
    step();
    bus.ival[1] = 1'b0;
    checks++;
    if (bus.ocount[1] !== 3'd3 || bus.iready[1] !== 1'b1) begin
      failures++; $display("FAIL full_push_pop cnt=%0d iready=%b exp=3/1", bus.ocount[1], bus.iready[1]);
    end
    for (int j = 1; j < 4; j++) begin
      checks++;
      if (bus.odata[1] !== vals[j]) begin failures++; $display("FAIL full_drain_%0d got=%0d exp=%0d", j, bus.odata[1], vals[j]); end
      step();
    end
    bus.oready[1] = 1'b0;
    checks++;
    if (bus.ocount[1] !== 3'd0) begin failures++; $display("FAIL full_rejected cnt=%0d exp=0", bus.ocount[1]); end
  endtask

  task automatic test_flush();
    bus.idata = {2'd1, 2'd2, 2'd0, 2'd3};
    bus.ival = 4'b1101;
    step();
    bus.ival = 4'b0101;
    step();
    bus.ival = 4'b0100;
    step();
    bus.ival = 4'b0000;
    checks++;
    if (bus.ocount !== {3'd1, 3'd3, 3'd0, 3'd2} || bus.oval !== 4'b1101) begin
      failures++; $display("FAIL preflush ocount=%h oval=%b exp=%h/1101", bus.ocount, bus.oval, {3'd1, 3'd3, 3'd0, 3'd2});
    end
    bus.flush = 1'b1;
    bus.ival = 4'b1111;
    bus.oready = 4'b1111;
    step();
    bus.flush = 1'b0;
    bus.ival = 4'b0000;
    bus.oready = 4'b0000;
    checks++;
    if (bus.ocount !== 12'd0 || bus.oval !== 4'b0000 || bus.oempty_all !== 1'b1 || bus.iready !== 4'b1111) begin
      failures++; $display("FAIL flush ocount=%h oval=%b oempty=%b iready=%b exp=000/0000/1/1111", bus.ocount, bus.oval, bus.oempty_all, bus.iready);
    end
    step();
    checks++;
    if (bus.ocount !== 12'd0) begin failures++; $display("FAIL flush_nowrite ocount=%h exp=000", bus.ocount); end
  endtask

  task automatic test_reset_mid();
    bus.ival[3] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus.idata[3] = 2'(i);
      step();
    end
    bus.ival[3] = 1'b0;
    bus.oready[3] = 1'b1;
    step();
    checks++;
    if (bus.ocount[3] !== 3'd2 || bus.odata[3] !== 2'd2) begin
      failures++; $display("FAIL middrain cnt=%0d data=%0d exp=2/2", bus.ocount[3], bus.odata[3]);
    end
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (bus.oval !== 4'b0000 || bus.ocount !== 12'd0 || bus.iready !== 4'b1111 || bus.oempty_all !== 1'b1) begin
      failures++; $display("FAIL async_reset oval=%b ocount=%h iready=%b oempty=%b exp=0000/000/1111/1", bus.oval, bus.ocount, bus.iready, bus.oempty_all);
    end
    #1 rstb = 1'b1;
    bus.oready[3] = 1'b0;
    bus.ival[3] = 1'b1;
    bus.idata[3] = 2'd2;
    step();
    bus.ival[3] = 1'b0;
    checks++;
    if (bus.ocount[3] !== 3'd1 || bus.odata[3] !== 2'd2 || bus.oval !== 4'b1000) begin
      failures++; $display("FAIL first_push cnt=%0d data=%0d oval=%b exp=1/2/1000", bus.ocount[3], bus.odata[3], bus.oval);
    end
    bus.oready[3] = 1'b1;
    step();
    bus.oready[3] = 1'b0;
  endtask

`ifdef COL_FIFO_PARITY_EN
  task automatic test_parity();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.ival = 4'b0011;
    bus.idata = {2'd0, 2'd0, 2'b11, 2'b01};
    bus.iparity = 4'b0000;
    step();
    bus.ival = 4'b0000;
    checks++;
    if (bus.oerr !== 4'b0000) begin failures++; $display("FAIL parity_prepop got=%b exp=0000", bus.oerr); end
    bus.oready = 4'b0011;
    step();
    bus.oready = 4'b0000;
    checks++;
    if (bus.oerr !== 4'b0001) begin failures++; $display("FAIL parity_set got=%b exp=0001", bus.oerr); end
    step();
    checks++;
    if (bus.oerr !== 4'b0001) begin failures++; $display("FAIL parity_sticky got=%b exp=0001", bus.oerr); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.oerr !== 4'b0000) begin failures++; $display("FAIL parity_flush got=%b exp=0000", bus.oerr); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
`ifdef COL_FIFO_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
